pattern_pack_gen: RTL and testbench
===================================

# pattern_pack_gen

Video source that produces the 50-bit pixel pack stream consumed by the processing chain (white balance and downstream stages). It generates complete frame timing (href, hsync, vsync, de, x, y) from programmable porch/sync parameters and fills active pixels with a selectable test pattern. It is the transmitter end of the pack interface, used as a camera substitute for bring-up and as the stimulus source for pipeline verification.

## Interface
- H_ACT, 1280: active pixels per line
- V_ACT, 720: active lines per frame
- H_FP / H_SYNC / H_BP, 110 / 40 / 220: horizontal front porch, sync width, back porch (pixels)
- V_FP / V_SYNC / V_BP, 5 / 5 / 20: vertical front porch, sync width, back porch (lines)
- HS_POL / VS_POL, 1 / 1: active level of hsync / vsync
- SOLID_RGB, 24'h808080: colour for mode 2, {r,g,b}
- clk  in  1  pixel clock; also carried in the pack clock field
- rst  in  1  asynchronous, active-high reset
- i_en  in  1  run request; sampled at frame boundaries
- i_mode  in  2  pattern select; latched at frame start
- o_pack  out  50  pixel pack, assembled by an hdmi_pack instance (x width $clog2(H_ACT), y width $clog2(V_ACT))
- o_frame_done  out  1  one-cycle pulse coincident with the last pack beat of each frame

## Operation
- H_TOTAL = H_ACT+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACT+V_FP+V_SYNC+V_BP.
- Counters h (0..H_TOTAL-1), v (0..V_TOTAL-1), frame counter fcnt (8 bit, wraps 255->0, incremented at each frame wrap).
- FSM states: IDLE, RUN.
  - IDLE: h=v=0 held; pack outputs blanked. i_en=1 -> RUN next cycle, h=v=0, mode latched from i_mode.
  - RUN: h increments; h=H_TOTAL-1 -> h=0, v+1. At h=H_TOTAL-1, v=V_TOTAL-1: i_en=1 -> wrap to (0,0), relatch mode, fcnt+1; i_en=0 -> IDLE.
  - i_en deassertion mid-frame never truncates a frame; i_mode changes mid-frame take effect only at next frame start.
- Region decode in RUN (IDLE: all inactive):
  - active = (h < H_ACT) && (v < V_ACT); de = href = active.
  - hsync active when H_ACT+H_FP <= h < H_ACT+H_FP+H_SYNC, every line.
  - vsync active when V_ACT+V_FP <= v < V_ACT+V_FP+V_SYNC, for all h of those lines.
  - x = h, y = v when active; x = y = 0 otherwise.
- Pattern (rgb forced to 0 when not active):
  - 0 colour bars: 8 equal bars, bar = largest k with x >= k*H_ACT/8 (integer division, constants); order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - 1 ramp: r = x[7:0], g = y[7:0], b = fcnt.
  - 2 solid: SOLID_RGB.
  - 3 checkerboard: (x[5] ^ y[5]) ? FFFFFF : 000000.
- Inactive sync level = !POL.

## Timing
- All pack fields and o_frame_done registered; o_pack at cycle t+1 reflects counter state at cycle t (latency 1).
- First active pixel (x=0,y=0, de=1) appears on o_pack 2 cycles after i_en is sampled high in IDLE.
- o_frame_done = 1 on the beat carrying h=H_TOTAL-1, v=V_TOTAL-1.
- Back-to-back frames: no gap cycles; frame period exactly H_TOTAL*V_TOTAL cycles.
- Reset (asynchronous, any time incl. mid-frame): FSM=IDLE, h=v=fcnt=0, latched mode=0, de=href=0, rgb=0, x=y=0, hsync=!HS_POL, vsync=!VS_POL, o_frame_done=0. Restart after release follows the IDLE rule.

## Test plan
Bench params: H_ACT=16, V_ACT=8, H_FP=H_SYNC=H_BP=2, V_FP=V_SYNC=V_BP=1 (H_TOTAL=22, V_TOTAL=11, 242 cycles/frame).
- i_en=1 held, mode 0 -> 128 de beats per frame, 8 per line; x=4,y=0 gives rgb 00FFFF; x=14 gives 000000; frame_done period 242 cycles.
- Sync placement -> hsync active for h=18,19 each line (2 beats); vsync active for full line v=9 (22 beats), rising edge one cycle after beat h=21,v=8.
- Mode 1 over 3 frames -> pixel (5,3) = {05,03,fcnt} with b = 0,1,2 in successive frames.
- i_mode 0->3 asserted mid-frame -> current frame remains bars; next frame pixel (0,0)=000000, checkerboard pattern with H_ACT=16 uses x[5]=0 -> pixel (x,y) black for y<8.
- i_en dropped mid-frame -> frame completes (frame_done pulses), then de/syncs inactive indefinitely; reassert -> (0,0) beat 2 cycles later.
- rst asserted at mid-active pixel -> outputs go to reset values without clock edge; after release with i_en=1, restarted frame begins at (0,0), fcnt=0.

Source files
------------

// File: rtl/pattern_pack_gen.sv
// Test-pattern video source: generates frame timing from programmable
// porch/sync parameters and fills active pixels with a selectable pattern,
// emitting the result as a 50-bit pixel pack.
//
// Pack layout (bit 49 down to 0):
//   [49] clk  [48] href  [47] hsync  [46] vsync  [45] de
//   [44:34] x (zero-extended)  [33:24] y (zero-extended)  [23:0] rgb {r,g,b}

// Assembles the pack word from its fields; x/y are zero-extended to the
// fixed 11/10-bit pack slots.
module hdmi_pack #(
  parameter int XW = 11,
  parameter int YW = 10
) (
  input  logic          clk,
  input  logic          href,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          de,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [23:0]   rgb,
  output logic [49:0]   pack
);
  assign pack = {clk, href, hsync, vsync, de, 11'(x), 10'(y), rgb};
endmodule

module pattern_pack_gen #(
  parameter int          H_ACT     = 1280,
  parameter int          V_ACT     = 720,
  parameter int          H_FP      = 110,
  parameter int          H_SYNC    = 40,
  parameter int          H_BP      = 220,
  parameter int          V_FP      = 5,
  parameter int          V_SYNC    = 5,
  parameter int          V_BP      = 20,
  parameter bit          HS_POL    = 1'b1,
  parameter bit          VS_POL    = 1'b1,
  parameter logic [23:0] SOLID_RGB = 24'h808080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [1:0]  i_mode,
  output logic [49:0] o_pack,
  output logic        o_frame_done
);
  localparam int XW = $clog2(H_ACT);
  localparam int YW = $clog2(V_ACT);

  localparam logic [15:0] H_ACT_C  = 16'(H_ACT);
  localparam logic [15:0] V_ACT_C  = 16'(V_ACT);
  localparam logic [15:0] H_LAST   = 16'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_LAST   = 16'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] HS_BEG   = 16'(H_ACT + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACT + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG   = 16'(V_ACT + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACT + V_FP + V_SYNC);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [15:0] h_r, h_s, v_r, v_s;
  logic [7:0]  fcnt_r, fcnt_s;
  logic [1:0]  mode_r, mode_s;

  logic          run_s, active_s, hs_act_s, vs_act_s, done_s;
  logic [2:0]    bar_s;
  logic [23:0]   rgb_s;
  logic [XW-1:0] x_s;
  logic [YW-1:0] y_s;

  logic          href_r, hsync_r, vsync_r, de_r, done_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [23:0]   rgb_r;

  // Colour of each of the eight vertical bars, left to right.
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  // Next-state logic: frame-boundary run/stop decisions and raster counters.
  always_comb begin
    state_s = state_r;
    h_s     = h_r;
    v_s     = v_r;
    fcnt_s  = fcnt_r;
    mode_s  = mode_r;
    case (state_r)
      IDLE: begin
        h_s = 16'd0;
        v_s = 16'd0;
        if (i_en) begin
          state_s = RUN;
          mode_s  = i_mode;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (h_r == H_LAST) begin
          h_s = 16'd0;
          if (v_r == V_LAST) begin
            v_s = 16'd0;
            // Stop only here so a frame is never cut short.
            if (i_en) begin
              mode_s = i_mode;
              fcnt_s = fcnt_r + 8'd1;
            end else begin
              state_s = IDLE;
            end
          end else begin
            v_s = v_r + 16'd1;
          end
        end else begin
          h_s = h_r + 16'd1;
        end
      end
      default: begin
        state_s = IDLE;
        h_s     = 16'd0;
        v_s     = 16'd0;
      end
    endcase
  end

  // FSM state, raster position, frame count and latched pattern mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      h_r     <= 16'd0;
      v_r     <= 16'd0;
      fcnt_r  <= 8'd0;
      mode_r  <= 2'd0;
    end else begin
      state_r <= state_s;
      h_r     <= h_s;
      v_r     <= v_s;
      fcnt_r  <= fcnt_s;
      mode_r  <= mode_s;
    end
  end

  // Region decode and pattern generation for the current raster position.
  always_comb begin
    run_s    = (state_r == RUN);
    active_s = run_s && (h_r < H_ACT_C) && (v_r < V_ACT_C);
    hs_act_s = run_s && (h_r >= HS_BEG) && (h_r < HS_END);
    vs_act_s = run_s && (v_r >= VS_BEG) && (v_r < VS_END);
    done_s   = run_s && (h_r == H_LAST) && (v_r == V_LAST);
    bar_s    = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_r >= 16'((k * H_ACT) / 8)) begin
        bar_s = 3'(k);
      end else begin
        bar_s = bar_s;
      end
    end
    if (active_s) begin
      x_s = h_r[XW-1:0];
      y_s = v_r[YW-1:0];
      case (mode_r)
        2'd0:    rgb_s = bar_rgb(bar_s);
        2'd1:    rgb_s = {h_r[7:0], v_r[7:0], fcnt_r};
        2'd2:    rgb_s = SOLID_RGB;
        2'd3:    rgb_s = (h_r[5] ^ v_r[5]) ? 24'hFFFFFF : 24'h000000;
        default: rgb_s = 24'h000000;
      endcase
    end else begin
      x_s   = {XW{1'b0}};
      y_s   = {YW{1'b0}};
      rgb_s = 24'h000000;
    end
  end

  // Output register stage: every pack field lags the counters by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      href_r  <= 1'b0;
      de_r    <= 1'b0;
      hsync_r <= ~HS_POL;
      vsync_r <= ~VS_POL;
      x_r     <= {XW{1'b0}};
      y_r     <= {YW{1'b0}};
      rgb_r   <= 24'h000000;
      done_r  <= 1'b0;
    end else begin
      href_r  <= active_s;
      de_r    <= active_s;
      hsync_r <= hs_act_s ? HS_POL : ~HS_POL;
      vsync_r <= vs_act_s ? VS_POL : ~VS_POL;
      x_r     <= x_s;
      y_r     <= y_s;
      rgb_r   <= rgb_s;
      done_r  <= done_s;
    end
  end

  assign o_frame_done = done_r;

  hdmi_pack #(
    .XW (XW),
    .YW (YW)
  ) u_pack (
    .clk   (clk),
    .href  (href_r),
    .hsync (hsync_r),
    .vsync (vsync_r),
    .de    (de_r),
    .x     (x_r),
    .y     (y_r),
    .rgb   (rgb_r),
    .pack  (o_pack)
  );
endmodule

// File: tb/tb_pattern_pack_gen.sv
// Directed, table-driven bench for pattern_pack_gen using a small raster
// (16x8 active, 22x11 total, 242 cycles per frame).
module tb_pattern_pack_gen;
  localparam int FT = 242;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_en = 1'b0;
  logic [1:0]  i_mode = 2'd0;
  logic [49:0] o_pack;
  logic        o_frame_done;

  int n_err = 0;
  int n_chk = 0;
  int beat  = 0;

  typedef struct {
    string       name;
    logic [1:0]  mode;
    int          frame;
    int          h;
    int          v;
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl[24];

  pattern_pack_gen #(
    .H_ACT(16), .V_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .SOLID_RGB(24'h808080)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_en         (i_en),
    .i_mode       (i_mode),
    .o_pack       (o_pack),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  // Compare the whole pack (sampled while clk is low) plus frame_done.
  task automatic check_beat(input string name, input logic de, input logic hs,
                            input logic vs, input int x, input int y,
                            input logic [23:0] rgb, input logic done);
    logic [49:0] exp_pack;
    exp_pack = {1'b0, de, hs, vs, de, 11'(x), 10'(y), rgb};
    n_chk++;
    if (o_pack !== exp_pack || o_frame_done !== done) begin
      n_err++;
      $display("FAIL %s: pack=%h done=%b expected pack=%h done=%b",
               name, o_pack, o_frame_done, exp_pack, done);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Reset, then enable; returns at the negedge where beat 0 (h=0,v=0) is visible.
  task automatic start_gen(input logic [1:0] m);
    @(negedge clk); i_en = 1'b0; rst = 1'b1; i_mode = m;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); i_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    beat = 0;
  endtask

  task automatic advance_to(input int n);
    while (beat < n) begin
      @(negedge clk);
      beat++;
    end
  endtask

  initial begin
    int de_cnt, hs_cnt, vs_cnt, done_cnt, first_vs, done_at, k, bad, tgt;

    #1 rst = 1'b1;
    #2 check_beat("reset_state", 1'b0, 1'b0, 1'b0, 0, 0, 24'h000000, 1'b0);

    tbl[0]  = '{"bar_white",       2'd0, 0,  0,  0, 1'b1, 1'b0, 1'b0, 24'hFFFFFF};
    tbl[1]  = '{"bar_yellow",      2'd0, 0,  3,  2, 1'b1, 1'b0, 1'b0, 24'hFFFF00};
    tbl[2]  = '{"bar_cyan",        2'd0, 0,  4,  0, 1'b1, 1'b0, 1'b0, 24'h00FFFF};
    tbl[3]  = '{"bar_red",         2'd0, 0, 11,  7, 1'b1, 1'b0, 1'b0, 24'hFF0000};
    tbl[4]  = '{"bar_blue",        2'd0, 0, 13,  5, 1'b1, 1'b0, 1'b0, 24'h0000FF};
    tbl[5]  = '{"bar_black",       2'd0, 0, 14,  0, 1'b1, 1'b0, 1'b0, 24'h000000};
    tbl[6]  = '{"hblank_fp",       2'd0, 0, 16,  0, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[7]  = '{"hblank_pre_sync", 2'd0, 0, 17,  3, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[8]  = '{"hsync_first",     2'd0, 0, 18,  3, 1'b0, 1'b1, 1'b0, 24'h000000};
    tbl[9]  = '{"hsync_last",      2'd0, 0, 19,  3, 1'b0, 1'b1, 1'b0, 24'h000000};
    tbl[10] = '{"hsync_after",     2'd0, 0, 20,  3, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[11] = '{"vfp_line_end",    2'd0, 0, 21,  8, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[12] = '{"vsync_start",     2'd0, 0,  0,  9, 1'b0, 1'b0, 1'b1, 24'h000000};
    tbl[13] = '{"vsync_hsync",     2'd0, 0, 18,  9, 1'b0, 1'b1, 1'b1, 24'h000000};
    tbl[14] = '{"vsync_end",       2'd0, 0, 21,  9, 1'b0, 1'b0, 1'b1, 24'h000000};
    tbl[15] = '{"vbp_line",        2'd0, 0,  0, 10, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[16] = '{"frame_last",      2'd0, 0, 21, 10, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[17] = '{"ramp_f0",         2'd1, 0,  5,  3, 1'b1, 1'b0, 1'b0, 24'h050300};
    tbl[18] = '{"ramp_f1",         2'd1, 1,  5,  3, 1'b1, 1'b0, 1'b0, 24'h050301};
    tbl[19] = '{"ramp_f2",         2'd1, 2,  5,  3, 1'b1, 1'b0, 1'b0, 24'h050302};
    tbl[20] = '{"ramp_corner",     2'd1, 0, 15,  7, 1'b1, 1'b0, 1'b0, 24'h0F0700};
    tbl[21] = '{"solid",           2'd2, 0,  7,  5, 1'b1, 1'b0, 1'b0, 24'h808080};
    tbl[22] = '{"solid_blank",     2'd2, 0,  7,  8, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[23] = '{"checker",         2'd3, 0, 10,  6, 1'b1, 1'b0, 1'b0, 24'h000000};

    for (int i = 0; i < 24; i++) begin
      start_gen(tbl[i].mode);
      tgt = tbl[i].frame * FT + tbl[i].v * 22 + tbl[i].h;
      advance_to(tgt);
      check_beat(tbl[i].name, tbl[i].de, tbl[i].hs, tbl[i].vs,
                 tbl[i].de ? tbl[i].h : 0, tbl[i].de ? tbl[i].v : 0,
                 tbl[i].rgb, (tbl[i].h == 21 && tbl[i].v == 10));
    end

    // Whole-frame census and frame period.
    start_gen(2'd0);
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; done_cnt = 0; first_vs = -1; done_at = -1;
    for (int b = 0; b < FT; b++) begin
      if (b > 0) @(negedge clk);
      if (o_pack[45]) de_cnt++;
      if (o_pack[47]) hs_cnt++;
      if (o_pack[46]) begin
        vs_cnt++;
        if (first_vs < 0) first_vs = b;
      end
      if (o_frame_done) begin
        done_cnt++;
        done_at = b;
      end
    end
    check_int("de_beats_per_frame", de_cnt, 128);
    check_int("hsync_beats_per_frame", hs_cnt, 22);
    check_int("vsync_beats_per_frame", vs_cnt, 22);
    check_int("vsync_first_beat", first_vs, 198);
    check_int("done_pulses_per_frame", done_cnt, 1);
    check_int("done_beat", done_at, 241);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_frame_done && k < 300);
    check_int("frame_period", k, FT);

    // Mode change mid-frame takes effect at the next frame only.
    start_gen(2'd0);
    advance_to(2 * 22 + 3);
    i_mode = 2'd3;
    advance_to(4 * 22 + 4);
    check_beat("mode_hold_cyan", 1'b1, 1'b0, 1'b0, 4, 4, 24'h00FFFF, 1'b0);
    advance_to(FT);
    check_beat("mode3_next_00", 1'b1, 1'b0, 1'b0, 0, 0, 24'h000000, 1'b0);
    advance_to(FT + 4);
    check_beat("mode3_next_40", 1'b1, 1'b0, 1'b0, 4, 0, 24'h000000, 1'b0);

    // Enable dropped mid-frame: frame completes, then stays quiet; restart.
    start_gen(2'd0);
    advance_to(4 * 22 + 5);
    i_en = 1'b0;
    advance_to(FT - 1);
    check_beat("drop_done", 1'b0, 1'b0, 1'b0, 0, 0, 24'h000000, 1'b1);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (o_pack[48:45] != 4'b0000 || o_frame_done) bad++;
    end
    check_int("idle_quiet", bad, 0);
    i_en = 1'b1;
    @(negedge clk);
    check_beat("restart_blank", 1'b0, 1'b0, 1'b0, 0, 0, 24'h000000, 1'b0);
    @(negedge clk);
    check_beat("restart_00", 1'b1, 1'b0, 1'b0, 0, 0, 24'hFFFFFF, 1'b0);

    // Asynchronous reset mid-active, then restart with frame count cleared.
    start_gen(2'd1);
    advance_to(FT + 3 * 22 + 5);
    check_beat("pre_reset_ramp", 1'b1, 1'b0, 1'b0, 5, 3, 24'h050301, 1'b0);
    #1 rst = 1'b1;
    #1 check_beat("async_reset", 1'b0, 1'b0, 1'b0, 0, 0, 24'h000000, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    beat = 0;
    check_beat("post_reset_00", 1'b1, 1'b0, 1'b0, 0, 0, 24'h000000, 1'b0);
    advance_to(3 * 22 + 5);
    check_beat("post_reset_fcnt0", 1'b1, 1'b0, 1'b0, 5, 3, 24'h050300, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
